// File: rtl/bcd_up_acc_if.sv
// bcd_up_acc_if: add-request handshake carrying the two-digit BCD addend
interface bcd_up_acc_if;
   logic       add_valid;
   logic       add_ready;
   logic [3:0] add_L;
   logic [3:0] add_M;
   modport master (output add_valid, add_L, add_M, input add_ready);
   modport slave (input add_valid, add_L, add_M, output add_ready);
endinterface

// File: rtl/bcd_up_acc.sv
// bcd_up_acc: three-digit BCD accumulator, digit-serial add with saturation at MAX
module bcd_up_acc #(
   parameter logic [3:0] INIT_H = 4'h0,
   parameter logic [3:0] INIT_M = 4'h0,
   parameter logic [3:0] INIT_L = 4'h0,
   parameter logic [3:0] MAX_H  = 4'h9,
   parameter logic [3:0] MAX_M  = 4'h9,
   parameter logic [3:0] MAX_L  = 4'h9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         loadN,
   input  logic         enable1,
   input  logic         enable2,
   bcd_up_acc_if.slave  bus,
   output logic [3:0]   countL,
   output logic [3:0]   countM,
   output logic [3:0]   countH,
   output logic         tc,
   output logic         ovf
);
   localparam logic [11:0] INIT = {INIT_H, INIT_M, INIT_L};
   localparam logic [11:0] MAX  = {MAX_H, MAX_M, MAX_L};

   typedef enum logic [2:0] {IDLE, ADD_L, ADD_M, ADD_H, CHK} state_t;
   state_t state, next_state;

   logic [3:0] opL, opM, sL, sM, sH;
   logic       carry, hc, hs, sat;
   logic [4:0] lsum, msum, hsum;

   assign bus.add_ready = (state == IDLE) & enable1 & enable2 & loadN & ~reset;
   assign hs = bus.add_valid & bus.add_ready;
   assign tc = ({countH, countM, countL} == MAX);

   always_comb begin
      next_state = !loadN            ? IDLE :
                   (state == IDLE)   ? (hs ? ADD_L : IDLE) :
                   (state == ADD_L)  ? ADD_M :
                   (state == ADD_M)  ? ADD_H :
                   (state == ADD_H)  ? CHK : IDLE;
      lsum = {1'b0, sL} + {1'b0, opL};
      msum = {1'b0, sM} + {1'b0, opM} + {4'b0, carry};
      hsum = {1'b0, sH} + {4'b0, carry};
      sat  = hc | ({sH, sM, sL} > MAX);
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= next_state;

   // the working sum lives in sL/sM/sH so the count only moves in CHK
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         {countH, countM, countL} <= '0;
         ovf <= 1'b0;
         {opL, opM, sL, sM, sH} <= '0;
         carry <= 1'b0;
         hc <= 1'b0;
      end else if (!loadN) begin
         {countH, countM, countL} <= INIT;
         ovf <= 1'b0;
      end else begin
         if (hs) begin
            opL <= (bus.add_L > 4'd9) ? 4'd9 : bus.add_L;
            opM <= (bus.add_M > 4'd9) ? 4'd9 : bus.add_M;
            {sH, sM, sL} <= {countH, countM, countL};
            carry <= 1'b0;
            hc <= 1'b0;
         end
         if (state == ADD_L) begin
            sL <= (lsum > 5'd9) ? 4'(lsum - 5'd10) : lsum[3:0];
            carry <= lsum > 5'd9;
         end
         if (state == ADD_M) begin
            sM <= (msum > 5'd9) ? 4'(msum - 5'd10) : msum[3:0];
            carry <= msum > 5'd9;
         end
         if (state == ADD_H) begin
            sH <= (hsum > 5'd9) ? 4'(hsum - 5'd10) : hsum[3:0];
            hc <= hsum > 5'd9;
         end
         if (state == CHK) begin
            {countH, countM, countL} <= sat ? MAX : {sH, sM, sL};
            ovf <= ovf | sat;
         end
      end
endmodule

// File: tb/tb_bcd_up_acc.sv
// tb_bcd_up_acc: two parameterisations driven in lockstep against a decimal model
module tb_bcd_up_acc;
   logic clk = 1'b0, reset = 1'b1, loadN = 1'b1, enable1 = 1'b1, enable2 = 1'b1;
   logic [3:0] l0, m0, h0, l1, m1, h1;
   logic tc0, tc1, ov0, ov1;
   int checks = 0, failures = 0;
   int v[2], ov[2];
   int maxv[2] = '{999, 150};

   bcd_up_acc_if i0 ();
   bcd_up_acc_if i1 ();

   bcd_up_acc #(.INIT_H(4'h2), .INIT_M(4'h5), .INIT_L(4'h0)) d0 (
      .clk(clk), .reset(reset), .loadN(loadN), .enable1(enable1), .enable2(enable2),
      .bus(i0.slave), .countL(l0), .countM(m0), .countH(h0), .tc(tc0), .ovf(ov0));

   bcd_up_acc #(.INIT_H(4'h2), .INIT_M(4'h5), .INIT_L(4'h0),
                .MAX_H(4'h1), .MAX_M(4'h5), .MAX_L(4'h0)) d1 (
      .clk(clk), .reset(reset), .loadN(loadN), .enable1(enable1), .enable2(enable2),
      .bus(i1.slave), .countL(l1), .countM(m1), .countH(h1), .tc(tc1), .ovf(ov1));

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] bcd(input int x);
      return 32'(((x / 100) << 8) | (((x / 10) % 10) << 4) | (x % 10));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag, input logic rdy);
      chk({tag, "_cnt0"}, 32'({h0, m0, l0}), bcd(v[0]));
      chk({tag, "_cnt1"}, 32'({h1, m1, l1}), bcd(v[1]));
      chk({tag, "_tc0"}, 32'(tc0), 32'(v[0] == maxv[0]));
      chk({tag, "_tc1"}, 32'(tc1), 32'(v[1] == maxv[1]));
      chk({tag, "_ovf0"}, 32'(ov0), 32'(ov[0]));
      chk({tag, "_ovf1"}, 32'(ov1), 32'(ov[1]));
      chk({tag, "_rdy0"}, 32'(i0.add_ready), 32'(rdy));
      chk({tag, "_rdy1"}, 32'(i1.add_ready), 32'(rdy));
   endtask

   task automatic drive(input logic vld, input logic [3:0] m, input logic [3:0] l);
      i0.add_valid = vld; i0.add_M = m; i0.add_L = l;
      i1.add_valid = vld; i1.add_M = m; i1.add_L = l;
   endtask

   task automatic model_add(input logic [3:0] m, input logic [3:0] l);
      int a = (m > 9 ? 9 : int'(m)) * 10 + (l > 9 ? 9 : int'(l));
      for (int k = 0; k < 2; k++)
         if (v[k] + a > maxv[k]) begin v[k] = maxv[k]; ov[k] = 1; end
         else v[k] = v[k] + a;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      v = '{0, 0}; ov = '{0, 0};
      check_state("rst", 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_state("rst_rel", 1'b1);
   endtask

   task automatic do_load();
      loadN = 1'b0;
      @(negedge clk);
      loadN = 1'b1;
      #1;
      v = '{250, 250}; ov = '{0, 0};
      check_state("load", 1'b1);
   endtask

   // handshake, confirm the old count holds through the four busy cycles, then the result
   task automatic do_add(input logic [3:0] m, input logic [3:0] l);
      int n = 0;
      while (!i0.add_ready && n < 20) begin @(negedge clk); n++; end
      chk("hs_wait", 32'(i0.add_ready), 32'd1);
      drive(1'b1, m, l);
      @(negedge clk);
      drive(1'b0, 4'($urandom), 4'($urandom));
      for (int k = 0; k < 4; k++) begin
         check_state("busy", 1'b0);
         enable1 = 1'($urandom);
         enable2 = 1'($urandom);
         @(negedge clk);
      end
      enable1 = 1'b1; enable2 = 1'b1;
      #1;
      model_add(m, l);
      check_state("done", 1'b1);
   endtask

   initial begin
      drive(1'b0, 4'h0, 4'h0);
      do_reset();
      do_add(4'h2, 4'h7);
      do_add(4'h6, 4'h8);
      do_add(4'h0, 4'h7);
      do_reset();
      do_add(4'hA, 4'hC);
      do_add(4'h4, 4'h1);
      do_add(4'h1, 4'h5);
      do_add(4'h0, 4'h0);
      do_load();
      chk("init_gt_max_tc", 32'(tc1), 32'd0);
      do_add(4'h0, 4'h0);
      for (int k = 0; k < 7; k++) do_add(4'h9, 4'h9);
      do_add(4'h5, 4'h2);
      do_add(4'h1, 4'h0);
      do_add(4'h0, 4'h1);
      // load pulse sampled while the in-flight add sits in ADD_M
      @(negedge clk);
      drive(1'b1, 4'h3, 4'h3);
      @(negedge clk);
      drive(1'b0, 4'h0, 4'h0);
      @(negedge clk);
      loadN = 1'b0;
      @(negedge clk);
      loadN = 1'b1;
      #1;
      v = '{250, 250}; ov = '{0, 0};
      check_state("abort", 1'b1);
      repeat (5) @(negedge clk);
      check_state("abort_hold", 1'b1);
      enable2 = 1'b0;
      drive(1'b1, 4'h1, 4'h1);
      repeat (10) begin
         @(negedge clk);
         check_state("gated", 1'b0);
      end
      drive(1'b0, 4'h0, 4'h0);
      enable2 = 1'b1;
      drive(1'b1, 4'h4, 4'h4);
      @(negedge clk);
      drive(1'b0, 4'h0, 4'h0);
      @(negedge clk);
      do_reset();
      repeat (5) @(negedge clk);
      check_state("rst_hold", 1'b1);
      for (int k = 0; k < 30; k++)
         if ($urandom_range(0, 7) == 0) do_load();
         else do_add(4'($urandom), 4'($urandom));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bcd_up_acc.md
BCD_UP_ACC -- requirements
Module: bcd_up_acc

Interface
REQ-001 The module SHALL have parameters INIT_H, INIT_M, INIT_L (4 bits each, default 4'h0, 4'h0, 4'h0), giving the BCD value loaded by loadN.
REQ-002 The module SHALL have parameters MAX_H, MAX_M, MAX_L (4 bits each, default 4'h9, 4'h9, 4'h9), giving the BCD saturation ceiling.
REQ-003 Port clk: input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset: input, 1 bit, asynchronous active-high reset.
REQ-005 Port loadN: input, 1 bit, synchronous active-low load of the INIT value.
REQ-006 Ports enable1 and enable2: inputs, 1 bit each, acceptance gates; both must be 1 for a request to be accepted.
REQ-007 Port add_valid: input, 1 bit, add request strobe.
REQ-008 Port add_ready: output, 1 bit, high when the block can accept a request.
REQ-009 Ports add_L and add_M: inputs, 4 bits each, BCD addend low and middle digits (addend range 0-99).
REQ-010 Ports countL, countM, countH: outputs, 4 bits each, the BCD accumulated value.
REQ-011 Port tc: output, 1 bit, high when the count equals MAX.
REQ-012 Port ovf: output, 1 bit, sticky flag set when saturation occurs.

Function
REQ-013 The FSM SHALL have the states IDLE, ADD_L, ADD_M, ADD_H and CHK.
REQ-014 add_ready SHALL equal (state==IDLE) & enable1 & enable2 & loadN & ~reset.
REQ-015 A handshake SHALL occur when add_valid & add_ready at a rising edge; at that edge the operands are captured into shadow registers, the shadow sum is seeded from the count, and the FSM goes IDLE->ADD_L.
REQ-016 Each captured operand digit greater than 9 SHALL be clamped to 9.
REQ-017 ADD_L SHALL compute sumL = countL + opL, then set the carry and subtract 10 if the result is greater than 9; the FSM then goes ADD_L->ADD_M.
REQ-018 ADD_M SHALL compute the same for countM + opM + carry; the FSM then goes ADD_M->ADD_H.
REQ-019 ADD_H SHALL compute countH + carry and record a carry out of the H digit; the FSM then goes ADD_H->CHK.
REQ-020 CHK SHALL write the sum to the count outputs atomically, unless there was an H carry-out or the sum is greater than MAX.
  - In either of those cases the count SHALL be set to MAX and ovf set to 1.
  - The FSM then goes CHK->IDLE.
REQ-021 The count outputs SHALL change only in CHK, on load, or on reset; intermediate digits SHALL never be visible.
REQ-022 Latency: with a handshake at edge N, the new count SHALL be visible after edge N+4, and add_ready SHALL be high again after edge N+4.
REQ-023 Maximum throughput SHALL be one request per 5 cycles.
REQ-024 A request arriving at MAX SHALL still run the full sequence, and the count SHALL remain MAX.
REQ-025 A zero addend SHALL run the full sequence with no change to the count.
REQ-026 Deasserting enable1 or enable2 after acceptance SHALL NOT abort an in-flight operation; the enables gate acceptance only.
REQ-027 When loadN=0 at an edge, the block SHALL load INIT into the count, clear ovf, abort any operation, and force the FSM to IDLE.
  - loadN SHALL take priority over every FSM action.
REQ-028 tc SHALL be purely combinational from the count registers: tc = ({countH,countM,countL} == {MAX_H,MAX_M,MAX_L}).
REQ-029 If INIT is greater than MAX, the block SHALL load INIT unchanged.
  - tc stays 0 in that case.
  - The next completed add SHALL saturate to MAX and set ovf.
REQ-030 ovf SHALL be cleared only by reset or by a load.

Reset
REQ-031 While reset=1, the count SHALL be 000, ovf 0, the FSM in IDLE, shadow registers 0, and add_ready 0, asynchronously.
REQ-032 Reset SHALL take priority over loadN.
REQ-033 Reset asserted mid-operation SHALL discard the operation; no partial update shall appear.
REQ-034 The first handshake SHALL be possible at the first rising edge after reset deasserts.

Verification
REQ-035 Scenario: reset, then add_M=2, add_L=7 accepted at edge N -> count 027 after edge N+4, tc=0, ovf=0.
REQ-036 Scenario: count 095, then add 07 -> count 102 (carry through two digits); the count reads 095 until edge N+4.
REQ-037 Scenario: count 995, then add 10 -> count 999, ovf=1, tc=1; a further add of 01 -> count stays 999, ovf stays 1.
REQ-038 Scenario: INIT=250, loadN=0 one cycle during ADD_M of an in-flight add -> count 250, ovf=0, FSM IDLE, add_ready=1 the next cycle.
REQ-039 Scenario: enable2=0 with add_valid=1 held for 10 cycles -> add_ready=0 and the count unchanged throughout.
REQ-040 Scenario: count 000, then add_M=4'hA, add_L=4'hC -> both digits clamped, count 099.
REQ-041 Scenario: MAX=150, count 140, then add 15 -> count 150, ovf=1, tc=1.
